digit_serial_alu: RTL
=====================

Name: digit_serial_alu

Overview:
Parametrised multi-cycle ALU. It processes operands LSB-first, DIGIT bits per clock, using one DIGIT-wide ripple adder slice and a carry flip-flop. It is the next generation of the team's bit-serial adder: generalised width and digit size, full op set, start/done handshake and the standard ZF/CF/OF/SF/PF flags. It sits beside the combinational ALU for area-constrained datapaths.

Parameters:
WIDTH, 32, operand and result width in bits.
DIGIT, 4, bits processed per RUN cycle. WIDTH % DIGIT != 0 is an elaboration error. DIGIT == WIDTH is legal.

Ports:
clk    in   1      clock, rising edge.
Rst    in   1      reset, synchronous, active-high.
start  in   1      request; sampled only when ready=1.
OP     in   3      000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLTU, 111 SLT.
A      in   WIDTH  left operand; captured on the accepted start.
B      in   WIDTH  right operand; captured on the accepted start.
ready  out  1      1 in IDLE only.
busy   out  1      1 in RUN only.
done   out  1      one-cycle pulse; F and flags are valid from this cycle.
F      out  WIDTH  result.
ZF     out  1      F == 0.
CF     out  1      carry/borrow flag.
OF     out  1      signed overflow flag.
SF     out  1      F[WIDTH-1].
PF     out  1      1 when F has an even number of ones (~^F).

Behaviour:
- Reset (sampled at rising edge with Rst=1):
  - State goes to IDLE.
  - F and all flags = 0; done = 0; busy = 0; ready = 1.
  - Any in-flight operation is discarded and its done never fires.
  - Rst has priority over start.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1: latch A, B, OP into shift registers; set digit counter = WIDTH/DIGIT.
  - Seed carry with 1 for SUB/SLTU/SLT (A + ~B + 1), else 0.
  - Go to RUN.
- RUN, each cycle:
  - Operate on the low DIGIT bits of the A/B shift registers (B inverted for SUB/SLTU/SLT).
  - Shift the result digit into the top of the result register; shift A/B right by DIGIT.
  - Update the carry FF; decrement the counter.
  - On the last digit, also capture the MSB carry-in (c_in_msb) and the final carry-out (c_out). Go to DONE.
- DONE (exactly one cycle):
  - done = 1; F and flags update this cycle.
  - Return to IDLE.
- Latency: done is high in the cycle after WIDTH/DIGIT+1 rising edges following the edge that accepted start. WIDTH=32, DIGIT=4 gives 9 edges; next start can be accepted the following edge.
- F and flags hold their value from the last done until the next done or Rst. They are not disturbed during RUN.
- start while busy or in DONE is ignored: no queueing, no effect on the running operation.
- Result and flag rules:
  - AND/OR/XOR/NOR: bitwise result; CF = 0, OF = 0.
  - ADD: F = A + B mod 2^WIDTH; CF = c_out; OF = c_in_msb ^ c_out.
  - SUB: F = A − B; CF = ~c_out (borrow); OF = c_in_msb ^ c_out.
  - SLTU: F = zero-extended ~c_out (A < B unsigned); CF = 0, OF = 0.
  - SLT: F = zero-extended (diff_msb ^ OF_sub) (A < B signed); CF = 0, OF = 0.
  - ZF, SF, PF are always derived from the final F.
- Operands changing during RUN have no effect.

Test Plan:
- ADD, A=0xFFFFFFFF, B=0x00000001 → F=0x00000000, ZF=1, CF=1, OF=0, SF=0, PF=1; done exactly 9 edges after start; busy high for 8 cycles.
- SUB, A=0x80000000, B=0x00000001 → F=0x7FFFFFFF, OF=1, CF=0, SF=0, PF=0. SUB, A=5, B=7 → F=0xFFFFFFFE, CF=1, SF=1, OF=0.
- A=0xFFFFFFFF, B=0x00000001 → SLT gives F=1; SLTU gives F=0. NOR A=0, B=0 → F=0xFFFFFFFF, PF=1, ZF=0.
- ADD start, then Rst asserted 4 edges later → next cycle ready=1, busy=0, F=0, flags=0; no done pulse follows. A new start (OR, A=0xF0, B=0x0F) then completes with F=0xFF.
- ADD 1+1 accepted; a second start with SUB 9−3 during RUN → only one done, F=2; following ready=1 cycle accepts the next op normally.
- Instances DIGIT=1 and DIGIT=32, ADD 0x12345678 + 0x11111111 → F=0x23456789, CF=0; done after 33 and 2 edges respectively.

Source files
------------

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: walks operands LSB-first, DIGIT bits per clock, through one
// DIGIT-wide adder slice plus a carry flop; result and flags register on exit from DONE.
module digit_serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             PF
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG + 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("digit_serial_alu: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  // SUB, SLTU and SLT all run as A + ~B + 1
  function automatic logic is_sub(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [2:0]       op_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             c_in_msb, c_out;

  logic [DIGIT-1:0]       a_dig, b_raw, b_dig, res_dig;
  logic [DIGIT:0]         sum;
  logic                   msb_cin;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   last_dig;

  always_ff @(posedge clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_dig) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign last_dig = (cnt == CNT_W'(1));
  assign a_dig    = a_sr[DIGIT-1:0];
  assign b_raw    = b_sr[DIGIT-1:0];
  assign b_dig    = is_sub(op_r) ? ~b_raw : b_raw;
  assign sum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
  // carry into the top bit of the slice recovered from the sum bit itself
  assign msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum[DIGIT-1];

  always_comb begin
    res_dig = sum[DIGIT-1:0];
    case (op_r)
      OP_AND:  res_dig = a_dig & b_raw;
      OP_OR:   res_dig = a_dig | b_raw;
      OP_XOR:  res_dig = a_dig ^ b_raw;
      OP_NOR:  res_dig = ~(a_dig | b_raw);
      default: res_dig = sum[DIGIT-1:0];
    endcase
  end

  // concatenate-then-slice keeps the shift legal when DIGIT == WIDTH
  assign res_cat = {res_dig, res_sr};

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      a_sr  <= A;
      b_sr  <= B;
      op_r  <= OP;
      carry <= is_sub(OP);
      cnt   <= CNT_W'(NDIG);
    end else if (state == S_RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_cat[WIDTH+DIGIT-1:DIGIT];
      carry  <= sum[DIGIT];
      cnt    <= cnt - CNT_W'(1);
      if (last_dig) begin
        c_in_msb <= msb_cin;
        c_out    <= sum[DIGIT];
      end
    end
  end

  logic             of_arith, cf_fin, of_fin;
  logic [WIDTH-1:0] f_fin;

  always_comb begin
    of_arith = c_in_msb ^ c_out;
    f_fin    = res_sr;
    cf_fin   = 1'b0;
    of_fin   = 1'b0;
    case (op_r)
      OP_ADD: begin
        cf_fin = c_out;
        of_fin = of_arith;
      end
      OP_SUB: begin
        cf_fin = ~c_out;
        of_fin = of_arith;
      end
      OP_SLTU: f_fin = {{(WIDTH-1){1'b0}}, ~c_out};
      OP_SLT:  f_fin = {{(WIDTH-1){1'b0}}, res_sr[WIDTH-1] ^ of_arith};
      default: f_fin = res_sr;
    endcase
  end

  // result stage: outputs only move on the edge that leaves DONE
  always_ff @(posedge clk) begin
    if (Rst) begin
      done <= 1'b0;
      F    <= '0;
      ZF   <= 1'b0;
      CF   <= 1'b0;
      OF   <= 1'b0;
      SF   <= 1'b0;
      PF   <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        F  <= f_fin;
        ZF <= ~|f_fin;
        CF <= cf_fin;
        OF <= of_fin;
        SF <= f_fin[WIDTH-1];
        PF <= ~^f_fin;
      end
    end
  end

endmodule
